// File: rtl/s2mm_dds_capture.sv
// AXI4-Stream capture of DDS samples into a bounded on-chip buffer, with
// optional alignment to and termination on pulse boundaries (tlast).
module s2mm_dds_capture #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              S_AXI_CLK,
   input  logic              S_AXI_ARESETN,
   input  logic [DATA_W-1:0] s_axis_dds_tdata,
   input  logic              s_axis_dds_tvalid,
   input  logic              s_axis_dds_tlast,
   output logic              s_axis_dds_tready,
   input  logic              arm_i,
   input  logic              abort_i,
   input  logic              align_i,
   input  logic              stop_on_tlast_i,
   input  logic [ADDR_W:0]   capture_len_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_valid_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              done_irq_o,
   output logic [ADDR_W:0]   sample_count_o,
   output logic              tlast_end_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

   state_e            state_q, state_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic              align_q, align_d;
   logic              stop_q, stop_d;
   logic              done_q, done_d;
   logic              irq_q, irq_d;
   logic              tlast_end_q, tlast_end_d;
   logic              tready_q;
   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_data_q;

   logic              beat;
   logic              wr_en;
   logic [ADDR_W:0]   count_inc;
   logic [ADDR_W:0]   len_clamped;

   logic [DATA_W-1:0] mem [DEPTH];

   assign beat      = s_axis_dds_tvalid && tready_q;
   assign count_inc = count_q + ONE_L;

   // Zero or oversize lengths both mean "fill the whole buffer".
   always_comb begin
      len_clamped = capture_len_i;
      if (capture_len_i == '0 || capture_len_i > DEPTH_L) begin
         len_clamped = DEPTH_L;
      end
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      len_d       = len_q;
      align_d     = align_q;
      stop_d      = stop_q;
      done_d      = done_q;
      irq_d       = 1'b0;
      tlast_end_d = tlast_end_q;
      wr_en       = 1'b0;

      if (abort_i) begin
         state_d = ST_IDLE;
         done_d  = 1'b0;
      end else if (arm_i) begin
         state_d     = ST_ARMED;
         count_d     = '0;
         done_d      = 1'b0;
         tlast_end_d = 1'b0;
         align_d     = align_i;
         stop_d      = stop_on_tlast_i;
         len_d       = len_clamped;
      end else begin
         unique case (state_q)
            ST_ARMED: begin
               // In aligned mode the pulse-ending tlast beat only opens the window.
               if (beat) begin
                  if (align_q) begin
                     if (s_axis_dds_tlast) state_d = ST_CAPTURE;
                  end else begin
                     wr_en = 1'b1;
                  end
               end
            end
            ST_CAPTURE: wr_en = beat;
            default: ;
         endcase

         if (wr_en) begin
            count_d = count_inc;
            if (count_inc == len_q || (stop_q && s_axis_dds_tlast)) begin
               state_d     = ST_DONE;
               done_d      = 1'b1;
               irq_d       = 1'b1;
               tlast_end_d = stop_q && s_axis_dds_tlast;
            end else begin
               state_d = ST_CAPTURE;
            end
         end
      end
   end

   always_ff @(posedge S_AXI_CLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         len_q       <= '0;
         align_q     <= 1'b0;
         stop_q      <= 1'b0;
         done_q      <= 1'b0;
         irq_q       <= 1'b0;
         tlast_end_q <= 1'b0;
         tready_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         len_q       <= len_d;
         align_q     <= align_d;
         stop_q      <= stop_d;
         done_q      <= done_d;
         irq_q       <= irq_d;
         tlast_end_q <= tlast_end_d;
         tready_q    <= 1'b1;
      end
   end

   // Buffer is deliberately not reset so it maps onto block RAM.
   always_ff @(posedge S_AXI_CLK) begin
      if (wr_en) mem[count_q[ADDR_W-1:0]] <= s_axis_dds_tdata;
   end

   always_ff @(posedge S_AXI_CLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_en_i;
         if (rd_en_i) rd_data_q <= mem[rd_addr_i];
      end
   end

   assign s_axis_dds_tready = tready_q;
   assign rd_data_o         = rd_data_q;
   assign rd_valid_o        = rd_valid_q;
   assign busy_o            = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
   assign done_o            = done_q;
   assign done_irq_o        = irq_q;
   assign sample_count_o    = count_q;
   assign tlast_end_o       = tlast_end_q;

endmodule
